// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared FSM states, header layout and burst address wrap for the SPI register slave.
package spi_reg_pkg;
   typedef enum logic [2:0] {IDLE, CMD, WR, RD, HOLD} state_t;
   localparam int HDR_W     = 16;
   localparam int RW_BIT    = 15;
   localparam int BURST_BIT = 14;
   function automatic int unsigned next_addr(input int unsigned addr, input int unsigned depth);
      return (addr + 1 == depth) ? 0 : addr + 1;
   endfunction
endpackage

// File: rtl/spi_in_sync.sv
// spi_in_sync: multi-flop synchroniser with one-flop rise/fall edge detect on the synchronised level.
module spi_in_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);
   logic [STAGES-1:0] sync_q;
   logic              prev_q;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         prev_q <= sync_q[STAGES-1];
      end
   end
   assign q_o    = sync_q[STAGES-1];
   assign rise_o = q_o & ~prev_q;
   assign fall_o = ~q_o & prev_q;
endmodule

// File: rtl/spi_reg_slave_sync.sv
// spi_reg_slave_sync: oversampled 3-wire SPI slave decoding header/data frames into a register file
// with burst access, range checking, abort detection and a registered local read port.
module spi_reg_slave_sync
   import spi_reg_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 256,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              sclk_i,
   input  logic              sen_i,
   input  logic              sdio_i,
   output logic              sdio_out_o,
   output logic              drive_sdio_o,
   output logic              wr_valid_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [DATA_W-1:0] wr_data_o,
   output logic [DATA_W-1:0] data_out_o,
   output logic              data_ready_o,
   output logic              frame_err_o,
   input  logic [ADDR_W-1:0] loc_raddr_i,
   output logic [DATA_W-1:0] loc_rdata_o
);
   localparam int SH_W  = (DATA_W > HDR_W) ? DATA_W : HDR_W;
   localparam int CNT_W = $clog2(SH_W);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   logic sclk_lvl, sclk_rise, sclk_fall, sen_lvl, sen_rise, sen_fall, sdio_lvl, sdio_rise, sdio_fall;
   spi_in_sync #(.STAGES(SYNC_STAGES)) u_sclk (.clk_i, .rst_i, .d_i(sclk_i), .q_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));
   spi_in_sync #(.STAGES(SYNC_STAGES)) u_sen  (.clk_i, .rst_i, .d_i(sen_i),  .q_o(sen_lvl),  .rise_o(sen_rise),  .fall_o(sen_fall));
   spi_in_sync #(.STAGES(SYNC_STAGES)) u_sdio (.clk_i, .rst_i, .d_i(sdio_i), .q_o(sdio_lvl), .rise_o(sdio_rise), .fall_o(sdio_fall));
   logic [DATA_W-1:0] mem_q [DEPTH];
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SH_W-1:0]   sh_q, sh_d, sh_n;
   logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_d;
   logic              burst_q, burst_d, load_q, load_d, mem_we;
   logic [DATA_W-1:0] tx_q, tx_d, word, wr_data_d, data_out_d, loc_rdata_d;
   logic              drive_d, sdo_d, wr_valid_d, data_ready_d, frame_err_d;
   logic [IDX_W-1:0]  aidx;
   logic              unused;
   assign unused = ^{sh_q[SH_W-1], sclk_lvl, sen_lvl, sdio_rise, sdio_fall};
   assign sh_n   = {sh_q[SH_W-2:0], sdio_lvl};
   assign word   = sh_n[DATA_W-1:0];
   assign aidx   = addr_q[IDX_W-1:0];
   assign loc_rdata_d = (32'(loc_raddr_i) < DEPTH) ? mem_q[loc_raddr_i[IDX_W-1:0]] : '0;
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sh_d         = sh_q;
      addr_d       = addr_q;
      burst_d      = burst_q;
      tx_d         = load_q ? mem_q[aidx] : tx_q;
      load_d       = 1'b0;
      drive_d      = drive_sdio_o;
      sdo_d        = sdio_out_o;
      wr_valid_d   = 1'b0;
      wr_addr_d    = wr_addr_o;
      wr_data_d    = wr_data_o;
      data_out_d   = data_out_o;
      data_ready_d = 1'b0;
      frame_err_d  = 1'b0;
      mem_we       = 1'b0;
      if (sen_rise) begin
         // SEN rise outranks a coincident SCLK rise, so that bit is dropped
         state_d     = IDLE;
         drive_d     = 1'b0;
         frame_err_d = (state_q inside {CMD, WR, RD}) && cnt_q != '0;
      end else begin
         case (state_q)
            IDLE: if (sen_fall) begin
               state_d = CMD;
               cnt_d   = '0;
               sh_d    = '0;
            end
            CMD: if (sclk_rise) begin
               sh_d  = sh_n;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(HDR_W-1)) begin
                  cnt_d   = '0;
                  addr_d  = sh_n[ADDR_W-1:0];
                  burst_d = sh_n[BURST_BIT];
                  if (32'(sh_n[ADDR_W-1:0]) >= DEPTH) begin
                     frame_err_d = 1'b1;
                     state_d     = HOLD;
                  end else begin
                     state_d = sh_n[RW_BIT] ? RD : WR;
                     load_d  = sh_n[RW_BIT];
                  end
               end
            end
            WR: if (sclk_rise) begin
               sh_d  = sh_n;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(DATA_W-1)) begin
                  cnt_d        = '0;
                  mem_we       = 1'b1;
                  wr_valid_d   = 1'b1;
                  wr_addr_d    = addr_q;
                  wr_data_d    = word;
                  data_out_d   = word;
                  data_ready_d = 1'b1;
                  addr_d       = burst_q ? ADDR_W'(next_addr(32'(addr_q), DEPTH)) : addr_q;
                  state_d      = burst_q ? WR : HOLD;
               end
            end
            RD: begin
               if (sclk_fall) begin
                  drive_d = 1'b1;
                  sdo_d   = tx_q[DATA_W-1];
                  tx_d    = tx_q << 1;
               end
               if (sclk_rise) begin
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == CNT_W'(DATA_W-1)) begin
                     cnt_d        = '0;
                     data_out_d   = mem_q[aidx];
                     data_ready_d = 1'b1;
                     addr_d       = burst_q ? ADDR_W'(next_addr(32'(addr_q), DEPTH)) : addr_q;
                     load_d       = burst_q;
                     state_d      = burst_q ? RD : HOLD;
                  end
               end
            end
            HOLD: if (sclk_fall) drive_d = 1'b0;
            default: state_d = HOLD;
         endcase
      end
   end
   // Reset parks in HOLD so a frame already in progress is ignored until SEN goes high
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= HOLD;
         cnt_q        <= '0;
         sh_q         <= '0;
         addr_q       <= '0;
         burst_q      <= 1'b0;
         load_q       <= 1'b0;
         tx_q         <= '0;
         sdio_out_o   <= 1'b0;
         drive_sdio_o <= 1'b0;
         wr_valid_o   <= 1'b0;
         wr_addr_o    <= '0;
         wr_data_o    <= '0;
         data_out_o   <= '0;
         data_ready_o <= 1'b0;
         frame_err_o  <= 1'b0;
         loc_rdata_o  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sh_q         <= sh_d;
         addr_q       <= addr_d;
         burst_q      <= burst_d;
         load_q       <= load_d;
         tx_q         <= tx_d;
         sdio_out_o   <= sdo_d;
         drive_sdio_o <= drive_d;
         wr_valid_o   <= wr_valid_d;
         wr_addr_o    <= wr_addr_d;
         wr_data_o    <= wr_data_d;
         data_out_o   <= data_out_d;
         data_ready_o <= data_ready_d;
         frame_err_o  <= frame_err_d;
         loc_rdata_o  <= loc_rdata_d;
      end
   end
   always_ff @(posedge clk_i) begin
      if (mem_we) mem_q[aidx] <= word;
   end
endmodule

// File: tb/tb_spi_reg_slave_sync.sv
// tb_spi_reg_slave_sync: directed SPI frames against hand-computed register contents and pulses.
module tb_spi_reg_slave_sync;
   localparam int HALF = 8;
   logic        clk = 1'b0, rst = 1'b1, sclk = 1'b0, sen = 1'b1, sdio = 1'b0;
   logic        sdio_out, drive_sdio, wr_valid, data_ready, frame_err;
   logic [11:0] wr_addr, loc_raddr = '0;
   logic [7:0]  wr_data, data_out, loc_rdata;
   int          vectors = 0, miscompares = 0;
   int          wr_cnt = 0, fe_cnt = 0, dr_cnt = 0;
   logic [11:0] last_wa = '0;
   logic [7:0]  last_wd = '0, last_do = '0;
   spi_reg_slave_sync dut (
      .clk_i(clk), .rst_i(rst), .sclk_i(sclk), .sen_i(sen), .sdio_i(sdio),
      .sdio_out_o(sdio_out), .drive_sdio_o(drive_sdio), .wr_valid_o(wr_valid),
      .wr_addr_o(wr_addr), .wr_data_o(wr_data), .data_out_o(data_out),
      .data_ready_o(data_ready), .frame_err_o(frame_err),
      .loc_raddr_i(loc_raddr), .loc_rdata_o(loc_rdata)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (wr_valid) begin
         wr_cnt++;
         last_wa = wr_addr;
         last_wd = wr_data;
      end
      if (data_ready) begin
         dr_cnt++;
         last_do = data_out;
      end
      if (frame_err) fe_cnt++;
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic bit_x(input logic b, output logic o, output logic de);
      sdio = b;
      repeat (HALF) @(negedge clk);
      o  = sdio_out;
      de = drive_sdio;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
   endtask
   task automatic send(input logic [15:0] w, input int n);
      logic o, de;
      for (int i = n - 1; i >= 0; i--) bit_x(w[i], o, de);
   endtask
   task automatic rd_word(output logic [7:0] v, output logic de_all);
      logic o, de;
      v = '0;
      de_all = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bit_x(1'b0, o, de);
         v = {v[6:0], o};
         de_all = de_all & de;
      end
   endtask
   task automatic start;
      sen = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask
   task automatic stop;
      repeat (HALF) @(negedge clk);
      sen = 1'b1;
      repeat (2 * HALF) @(negedge clk);
   endtask
   task automatic loc_rd(input logic [11:0] a, output logic [7:0] v);
      loc_raddr = a;
      repeat (2) @(negedge clk);
      v = loc_rdata;
   endtask
   initial begin
      int w0, f0, d0;
      logic [7:0] v;
      logic de;
      repeat (4) @(negedge clk);
      chk("rst_drive", drive_sdio, 0);
      chk("rst_sdo", sdio_out, 0);
      chk("rst_outs", {wr_valid, data_ready, frame_err, wr_addr, wr_data, data_out, loc_rdata}, 0);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      // single write
      w0 = wr_cnt; d0 = dr_cnt;
      start; send(16'h0005, 16); send(16'h00A5, 8); stop;
      chk("w1_cnt", wr_cnt - w0, 1);
      chk("w1_addr", last_wa, 12'h005);
      chk("w1_data", last_wd, 8'hA5);
      chk("w1_dr", dr_cnt - d0, 1);
      chk("w1_dout", data_out, 8'hA5);
      loc_rd(12'h005, v);
      chk("w1_loc", v, 8'hA5);
      // single read of 0x3C
      start; send(16'h0005, 16); send(16'h003C, 8); stop;
      d0 = dr_cnt;
      start; send(16'h8005, 16);
      chk("r_hdr_drive", drive_sdio, 0);
      rd_word(v, de);
      chk("r_drive", de, 1);
      chk("r_bits", v, 8'h3C);
      chk("r_dout", last_do, 8'h3C);
      chk("r_dr", dr_cnt - d0, 1);
      stop;
      chk("r_drive_off", drive_sdio, 0);
      // burst write wrapping 254,255,0
      w0 = wr_cnt; f0 = fe_cnt;
      start; send(16'h40FE, 16); send(16'h0011, 8); send(16'h0022, 8); send(16'h0033, 8); stop;
      chk("bw_cnt", wr_cnt - w0, 3);
      chk("bw_last_addr", last_wa, 12'h000);
      loc_rd(12'h0FE, v); chk("bw_254", v, 8'h11);
      loc_rd(12'h0FF, v); chk("bw_255", v, 8'h22);
      loc_rd(12'h000, v); chk("bw_0", v, 8'h33);
      // burst read wrapping 255 -> 0
      start; send(16'hC0FF, 16);
      rd_word(v, de); chk("br_w0", v, 8'h22);
      rd_word(v, de); chk("br_w1", v, 8'h33);
      chk("br_drive", de, 1);
      stop;
      chk("b_fe", fe_cnt - f0, 0);
      // out-of-range write
      w0 = wr_cnt; f0 = fe_cnt;
      start; send(16'h0100, 16); send(16'h00FF, 8); stop;
      chk("oor_fe", fe_cnt - f0, 1);
      chk("oor_wr", wr_cnt - w0, 0);
      loc_rd(12'h000, v); chk("oor_mem0", v, 8'h33);
      loc_rd(12'h100, v); chk("oor_loc", v, 8'h00);
      // aborted partial write
      start; send(16'h0007, 16); send(16'h005A, 8); stop;
      w0 = wr_cnt; f0 = fe_cnt;
      start; send(16'h0007, 16); send(16'h001F, 5); stop;
      chk("ab_fe", fe_cnt - f0, 1);
      chk("ab_wr", wr_cnt - w0, 0);
      loc_rd(12'h007, v); chk("ab_mem7", v, 8'h5A);
      // reset in the middle of a read
      start; send(16'h8005, 16); send(16'h0000, 3);
      chk("rr_drive_pre", drive_sdio, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rr_drive", drive_sdio, 0);
      chk("rr_outs", {sdio_out, wr_valid, data_ready, frame_err, wr_addr, wr_data, data_out, loc_rdata}, 0);
      rst = 1'b0;
      w0 = wr_cnt;
      repeat (4) @(negedge clk);
      send(16'h0009, 16); send(16'h0066, 8);
      chk("rr_ignored", wr_cnt - w0, 0);
      stop;
      start; send(16'h0009, 16); send(16'h0077, 8); stop;
      chk("rr_recover_cnt", wr_cnt - w0, 1);
      chk("rr_recover", {last_wa, last_wd}, {12'h009, 8'h77});
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
